// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: merges ALU results and load data into one small in-order
// queue that drains at most one register-file write per cycle, and flags
// read operands that still have a write pending in the queue or on the port.
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_addr,
    input  logic [63:0]            alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [4:0]             mem_addr,
    input  logic [63:0]            mem_data,
    output logic                   mem_ready,
    output logic                   write,
    output logic [4:0]             wrAddr,
    output logic [63:0]            wrData,
    input  logic [4:0]             rdAddrA,
    input  logic [4:0]             rdAddrB,
    output logic                   hazardA,
    output logic                   hazardB,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] DISCARD_ADDR = 5'd31;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          write_q, write_d;
    logic [4:0]    wrAddr_q, wrAddr_d;
    logic [63:0]   wrData_q, wrData_d;

    logic [4:0]    addrMem_q [DEPTH];
    logic [63:0]   dataMem_q [DEPTH];

    logic [CW-1:0] freeSlots;
    logic          memPush;
    logic          aluPush;
    logic          popNow;
    logic [PW-1:0] aluSlot;
    logic [PW-1:0] scanIdx;
    logic          hitA;
    logic          hitB;

    // Free space comes only from registered occupancy, so a pop in this
    // cycle never opens a slot early; the ALU yields a slot to a load.
    assign freeSlots = CW'(DEPTH) - count_q;
    assign mem_ready = (freeSlots >= CW'(1));
    assign alu_ready = mem_valid ? (freeSlots >= CW'(2)) : (freeSlots >= CW'(1));

    // Register 31 writes are accepted but never stored.
    assign memPush = mem_valid && mem_ready && (mem_addr != DISCARD_ADDR);
    assign aluPush = alu_valid && alu_ready && (alu_addr != DISCARD_ADDR);
    assign popNow  = (count_q != '0);
    assign aluSlot = memPush ? (tail_q + PW'(1)) : tail_q;

    // Next-state: pop the head into the write port, advance pointers and occupancy.
    always_comb begin
        head_d   = head_q;
        write_d  = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        if (popNow) begin
            write_d  = 1'b1;
            wrAddr_d = addrMem_q[head_q];
            wrData_d = dataMem_q[head_q];
            head_d   = head_q + PW'(1);
        end
        tail_d  = tail_q + PW'(memPush) + PW'(aluPush);
        count_d = count_q + CW'(memPush) + CW'(aluPush) - CW'(popNow);
    end

    // Control state and write port, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            write_q  <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            write_q  <= write_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
        end
    end

    // Entry storage; the load entry takes the older slot when both arrive together.
    always_ff @(posedge clock) begin
        if (memPush) begin
            addrMem_q[tail_q] <= mem_addr;
            dataMem_q[tail_q] <= mem_data;
        end
        if (aluPush) begin
            addrMem_q[aluSlot] <= alu_addr;
            dataMem_q[aluSlot] <= alu_data;
        end
    end

    // Scan occupied entries and the write port for a pending write to each read address.
    always_comb begin
        hitA    = 1'b0;
        hitB    = 1'b0;
        scanIdx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (addrMem_q[scanIdx] == rdAddrA) hitA = 1'b1;
                if (addrMem_q[scanIdx] == rdAddrB) hitB = 1'b1;
            end
        end
        if (write_q && (wrAddr_q == rdAddrA)) hitA = 1'b1;
        if (write_q && (wrAddr_q == rdAddrB)) hitB = 1'b1;
    end

    assign hazardA = hitA && (rdAddrA != DISCARD_ADDR);
    assign hazardB = hitB && (rdAddrB != DISCARD_ADDR);

    assign write  = write_q;
    assign wrAddr = wrAddr_q;
    assign wrData = wrData_q;
    assign count  = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: a reference queue model predicts readiness,
// hazards, occupancy and every register-file write, cycle by cycle.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        write;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic        hazardA;
    logic        hazardB;
    logic [2:0]  count;

    entry_t      expQ[$];
    logic        expWrite;
    logic [4:0]  expAddr;
    logic [63:0] expData;
    int          testsRun;
    int          testsFailed;
    int          enqueued;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .write     (write),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .hazardA   (hazardA),
        .hazardB   (hazardB),
        .count     (count)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // A read address is hazarded by any queued entry or by the write on the port.
    function automatic logic modelHazard(input logic [4:0] rd);
        logic hit;
        hit = 1'b0;
        if (rd == 5'd31) return 1'b0;
        foreach (expQ[i]) if (expQ[i].addr == rd) hit = 1'b1;
        if (expWrite && (expAddr == rd)) hit = 1'b1;
        return hit;
    endfunction

    // Drive one cycle of requests, check the pre-edge outputs, advance the
    // model across the edge, then check the post-edge outputs.
    task automatic applyStimulus(input logic mv, input logic [4:0] ma, input logic [63:0] md,
                                 input logic av, input logic [4:0] aa, input logic [63:0] ad);
        int     freeSlots;
        logic   expMemReady;
        logic   expAluReady;
        entry_t e;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        #1;
        freeSlots   = DEPTH - expQ.size();
        expMemReady = (freeSlots >= 1);
        expAluReady = mv ? (freeSlots >= 2) : (freeSlots >= 1);
        checkOutput("mem_ready", 64'(mem_ready), 64'(expMemReady));
        checkOutput("alu_ready", 64'(alu_ready), 64'(expAluReady));
        checkOutput("hazardA", 64'(hazardA), 64'(modelHazard(rdAddrA)));
        checkOutput("hazardB", 64'(hazardB), 64'(modelHazard(rdAddrB)));
        @(posedge clock);
        if (expQ.size() > 0) begin
            e        = expQ.pop_front();
            expWrite = 1'b1;
            expAddr  = e.addr;
            expData  = e.data;
        end else begin
            expWrite = 1'b0;
        end
        if (mv && expMemReady && (ma != 5'd31)) begin
            e.addr = ma;
            e.data = md;
            expQ.push_back(e);
            enqueued++;
        end
        if (av && expAluReady && (aa != 5'd31)) begin
            e.addr = aa;
            e.data = ad;
            expQ.push_back(e);
            enqueued++;
        end
        @(negedge clock);
        checkOutput("write", 64'(write), 64'(expWrite));
        checkOutput("wrAddr", 64'(wrAddr), 64'(expAddr));
        checkOutput("wrData", wrData, expData);
        checkOutput("count", 64'(count), 64'(expQ.size()));
    endtask

    // One cycle with no requests.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    // Main sequence.
    initial begin
        int cycles;
        int startEnq;
        testsRun    = 0;
        testsFailed = 0;
        enqueued    = 0;
        expWrite    = 1'b0;
        expAddr     = '0;
        expData     = '0;
        reset       = 1'b0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        rdAddrA     = 5'd5;
        rdAddrB     = 5'd7;

        // Reset state
        @(negedge clock);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_write", 64'(write), 64'd0);
        checkOutput("reset_wrAddr", 64'(wrAddr), 64'd0);
        checkOutput("reset_wrData", wrData, 64'd0);
        checkOutput("reset_hazardA", 64'(hazardA), 64'd0);
        checkOutput("reset_hazardB", 64'(hazardB), 64'd0);
        reset = 1'b1;

        // Single ALU write, two-edge latency
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234);
        idleCycles(3);

        // Simultaneous load and ALU: load drains first
        applyStimulus(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB);
        idleCycles(3);

        // Fill to three entries, then probe the readiness boundary
        applyStimulus(1'b1, 5'd10, 64'h100, 1'b1, 5'd11, 64'h101);
        applyStimulus(1'b1, 5'd12, 64'h102, 1'b1, 5'd13, 64'h103);
        checkOutput("count_at_3", 64'(count), 64'd3);
        applyStimulus(1'b1, 5'd14, 64'h104, 1'b1, 5'd15, 64'h105);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd16, 64'h106);
        idleCycles(5);

        // Register 31 is accepted but discarded
        rdAddrA = 5'd31;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF);
        idleCycles(3);

        // Hazard on r7 lasts through its write pulse
        rdAddrA = 5'd7;
        rdAddrB = 5'd9;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
        idleCycles(4);

        // Reset mid-operation with three entries queued
        rdAddrA = 5'd21;
        applyStimulus(1'b1, 5'd20, 64'h200, 1'b1, 5'd21, 64'h201);
        applyStimulus(1'b1, 5'd22, 64'h202, 1'b1, 5'd23, 64'h203);
        checkOutput("pre_reset_count", 64'(count), 64'd3);
        #2;
        reset     = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        #1;
        checkOutput("midreset_write", 64'(write), 64'd0);
        checkOutput("midreset_count", 64'(count), 64'd0);
        checkOutput("midreset_hazardA", 64'(hazardA), 64'd0);
        checkOutput("midreset_wrAddr", 64'(wrAddr), 64'd0);
        expQ.delete();
        expWrite = 1'b0;
        expAddr  = '0;
        expData  = '0;
        @(negedge clock);
        reset = 1'b1;
        idleCycles(4);

        // Wrap-around stream of at least ten entries, checked in order
        rdAddrA  = 5'd3;
        rdAddrB  = 5'd8;
        startEnq = enqueued;
        cycles   = 0;
        while ((enqueued - startEnq < 10) && (cycles < 40)) begin
            applyStimulus(cycles[0] == 1'b0, 5'(1 + (2 * cycles) % 30), 64'hD000 + 64'(cycles),
                          1'b1, 5'(2 + (2 * cycles) % 29), 64'hE000 + 64'(cycles));
            cycles++;
        end
        checkOutput("stream_within_bound", 64'(cycles < 40), 64'd1);
        idleCycles(6);
        checkOutput("final_count", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
